i2s_rx_ctrl: RTL and testbench
==============================

// Module: i2s_rx_ctrl
// PURPOSE
//   Deserialising sequencer for the I2S receive path. Samples LRCK/SDATA on
//   sck, frames each channel slot, assembles DATA_WIDTH-bit words MSB-first
//   with the standard one-bit delay. Drives data/l_vld/r_vld into the
//   downstream left/right holding registers (capture on the cycle after vld).
// PARAMETERS
//   DATA_WIDTH  8  bits captured per channel slot (MSB first); extra slot bits ignored
//   WS_LEFT     0  LRCK level that denotes the left channel
// PORTS
//   sck      in   1           bit clock; all logic on posedge
//   rst_n    in   1           asynchronous active-low reset
//   en       in   1           receive enable; 0 forces IDLE on next posedge
//   lrck     in   1           word select, synchronous to sck
//   sdata    in   1           serial data, synchronous to sck
//   data     out  DATA_WIDTH  last completed word; held until next word
//   l_vld    out  1           1-cycle pulse: data is a left word
//   r_vld    out  1           1-cycle pulse: data is a right word
//   synced   out  1           1 once a WS edge has been seen since reset/en
//   err_cnt  out  8           [I2S_RX_ERR_EN only] short-slot count, saturating
// BEHAVIOUR
//   Reset: data=0, l_vld=r_vld=0, synced=0, lrck_q=0, bit_cnt=0, state=IDLE,
//     shift reg=0, err_cnt=0.
//   ws_edge = (lrck != lrck_q); lrck_q <= lrck every posedge (also in IDLE).
//   Bit sampled on the ws_edge posedge is the LSB of the previous slot (dropped).
//   FSM (all transitions on posedge sck):
//     IDLE : wait; on en & ws_edge -> SHIFT, chan <= (lrck==WS_LEFT)?L:R,
//            bit_cnt<=0, synced<=1. First edge after reset only synchronises.
//     SHIFT: shift <= {shift, sdata}, bit_cnt++. When bit_cnt==DATA_WIDTH-1:
//            data <= {shift[DATA_WIDTH-2:0], sdata}; pulse l_vld if chan==L
//            else r_vld; -> WAIT.
//     WAIT : ignore sdata until ws_edge -> SHIFT (new chan, bit_cnt<=0).
//   Latency: WS edge at posedge E; MSB sampled at E+1, LSB at E+DATA_WIDTH;
//     data/vld registered at E+DATA_WIDTH, vld high exactly one cycle.
//   Short slot: ws_edge in SHIFT before bit_cnt reached DATA_WIDTH-1 ->
//     partial word discarded, no vld; restart SHIFT for new channel.
//   Slot exactly DATA_WIDTH bits: completion posedge coincides with the next
//     ws_edge -> emit word AND start the new slot in the same cycle (no loss).
//   l_vld and r_vld never both 1; data changes only on a vld cycle.
//   en=0: -> IDLE, synced<=0, in-flight word dropped, data holds its value,
//     no vld. Re-enable requires a fresh WS edge.
//   rst_n low mid-word: all state cleared immediately (async); no vld
//     until a new WS edge and a full slot.
//   bit_cnt width: $clog2(DATA_WIDTH)+1; it never wraps (stops at WAIT).
// CONFIGURATION
//   I2S_RX_ERR_EN defined: err_cnt port present; +1 on each short slot in
//     SHIFT (not in IDLE/WAIT), saturates at 8'hFF, cleared only by rst_n.
//   Not defined: port and counter absent; short slots dropped silently.
// TESTING (DATA_WIDTH=8, WS_LEFT=0)
//   32-sck stereo frame, L=8'hA5, R=8'h3C -> first frame sync only; then l_vld
//     with data=A5 at E+8, r_vld with data=3C at E'+8, one cycle each.
//   8-bit slots back-to-back (WS edge every 8 sck), L=8'h81, R=8'h7E -> every
//     word emitted, no dropped slots, vld pulses 8 cycles apart.
//   Slot of 5 bits then normal slot 8'hFF -> no vld for short slot, next word
//     FF correct; err_cnt 0->1 when I2S_RX_ERR_EN defined.
//   en deasserted mid-word at bit 4, reasserted -> no vld for that word,
//     synced=0, first vld only after the next WS edge plus a full slot.
//   rst_n pulsed low mid-slot -> data=0, vld=0, synced=0 immediately;
//     recovers on next frame.
//   300 consecutive short slots with I2S_RX_ERR_EN -> err_cnt saturates at FF.

Source files
------------

// File: rtl/i2s_rx_ctrl.sv
// I2S receive sequencer: samples lrck/sdata on posedge sck, frames each channel
// slot with the standard one-bit delay and assembles DATA_WIDTH-bit words
// MSB-first. Extra slot bits beyond DATA_WIDTH are ignored.
// Optional feature macro: I2S_RX_ERR_EN adds a saturating short-slot counter
// on port err_cnt.
module i2s_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter bit WS_LEFT    = 1'b0
) (
   input  logic                  sck,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  lrck,
   input  logic                  sdata,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  l_vld,
   output logic                  r_vld,
   output logic                  synced
`ifdef I2S_RX_ERR_EN
   ,
   output logic [7:0]            err_cnt
`endif
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic                    lrck_q;
   logic                    ws_edge;
   logic                    chan_left_q, chan_left_nxt;
   logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
   logic [DATA_WIDTH-2:0]   shift_q, shift_nxt;
   logic [DATA_WIDTH-1:0]   word;
   logic                    last_bit;
   logic                    word_done;
   logic                    start_slot;

   // The bit sampled on a WS edge belongs to the previous slot, so a word is
   // always the held DATA_WIDTH-1 bits plus the bit arriving this cycle.
   assign ws_edge  = (lrck != lrck_q);
   assign word     = {shift_q, sdata};
   assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

   // Word-select history, tracked in every state so edges are seen from IDLE.
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) lrck_q <= 1'b0;
      else        lrck_q <= lrck;
   end

   // FSM state register together with the slot framing registers.
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         chan_left_q <= 1'b0;
         bit_cnt     <= '0;
         shift_q     <= '0;
      end else begin
         state       <= state_nxt;
         chan_left_q <= chan_left_nxt;
         bit_cnt     <= bit_cnt_nxt;
         shift_q     <= shift_nxt;
      end
   end

   // Next-state logic: a WS edge always opens a new slot; completing the last
   // bit on that same edge still emits the finished word.
   always_comb begin
      state_nxt     = state;
      chan_left_nxt = chan_left_q;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift_q;
      word_done     = 1'b0;
      start_slot    = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, WAIT: begin
               if (ws_edge) start_slot = 1'b1;
            end
            SHIFT: begin
               if (last_bit) begin
                  word_done = 1'b1;
                  state_nxt = WAIT;
               end else begin
                  shift_nxt   = word[DATA_WIDTH-2:0];
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
               end
               if (ws_edge) start_slot = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
      if (start_slot) begin
         state_nxt     = SHIFT;
         chan_left_nxt = (lrck == WS_LEFT);
         bit_cnt_nxt   = '0;
         shift_nxt     = '0;
      end
   end

   // Output word and one-cycle channel strobes; data holds between words.
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         l_vld <= 1'b0;
         r_vld <= 1'b0;
      end else begin
         l_vld <= word_done & chan_left_q;
         r_vld <= word_done & ~chan_left_q;
         if (word_done) data <= word;
      end
   end

   // Sync flag: set by the first framed WS edge, dropped whenever disabled.
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n)          synced <= 1'b0;
      else if (!en)        synced <= 1'b0;
      else if (start_slot) synced <= 1'b1;
   end

`ifdef I2S_RX_ERR_EN
   logic short_slot;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A WS edge while still shifting means the slot ended before a full word.
   assign short_slot = en && (state == SHIFT) && ws_edge && !last_bit;

   // Short-slot counter, saturating, cleared only by reset.
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n)          err_cnt <= 8'h00;
      else if (short_slot) err_cnt <= sat_inc(err_cnt);
   end
`endif

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Self-checking bench for i2s_rx_ctrl (DATA_WIDTH=8, WS_LEFT=0). The reference
// model keeps the cycle history of lrck/sdata/en and derives expected outputs
// from slot timing: a word is due DATA_WIDTH cycles after an enabled WS edge
// when no other edge intervened and en stayed high throughout.
module tb_i2s_rx_ctrl;

   localparam int   DW  = 8;
   localparam logic WSL = 1'b0;
   localparam int   HMAX = 8192;

   logic       sck   = 1'b0;
   logic       rst_n = 1'b1;
   logic       en    = 1'b0;
   logic       lrck  = 1'b0;
   logic       sdata = 1'b0;
   logic [7:0] data;
   logic       l_vld, r_vld, synced;
`ifdef I2S_RX_ERR_EN
   logic [7:0] err_cnt;
`endif

   i2s_rx_ctrl #(.DATA_WIDTH(DW), .WS_LEFT(WSL)) dut (
      .sck    (sck),
      .rst_n  (rst_n),
      .en     (en),
      .lrck   (lrck),
      .sdata  (sdata),
      .data   (data),
      .l_vld  (l_vld),
      .r_vld  (r_vld),
      .synced (synced)
`ifdef I2S_RX_ERR_EN
      ,
      .err_cnt(err_cnt)
`endif
   );

   always #5 sck = ~sck;

   int         checks = 0;
   int         errors = 0;
   logic       lr_h [HMAX];
   logic       sd_h [HMAX];
   logic       en_h [HMAX];
   int         n = 0;
   logic       exp_syn = 1'b0;
   logic [7:0] exp_data = 8'h00;
   int         exp_err = 0;
   logic       en_drv = 1'b1;
   logic       pend = 1'b0;
   logic [7:0] last_l = 8'h00, last_r = 8'h00;
   int         l_cnt = 0, r_cnt = 0;
   bit         b2b_on = 1'b0;
   int         b2b_cnt = 0, last_vld_n = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, n);
      end
   endtask

   function automatic bit ws_at(input int i);
      return (i == 0) ? (lr_h[0] != 1'b0) : (lr_h[i] != lr_h[i-1]);
   endfunction

   function automatic bit en_span(input int a, input int b);
      for (int i = a; i <= b; i++) if (!en_h[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_eval();
      int         e;
      bit         ok;
      logic [7:0] w;
      bit         el, er;
      exp_syn = en_h[n] ? (exp_syn | ws_at(n)) : 1'b0;
      el = 1'b0;
      er = 1'b0;
      e  = n - DW;
      if (e >= 0 && ws_at(e) && en_span(e, n)) begin
         ok = 1'b1;
         for (int i = e + 1; i < n; i++) if (ws_at(i)) ok = 1'b0;
         if (ok) begin
            w = 8'h00;
            for (int k = 1; k <= DW; k++) w = {w[DW-2:0], sd_h[e+k]};
            exp_data = w;
            el = (lr_h[e] == WSL);
            er = !el;
         end
      end
      if (ws_at(n) && en_h[n]) begin
         for (int i = n - 1; i > n - DW && i >= 0; i--) begin
            if (ws_at(i)) begin
               if (en_span(i, n) && exp_err < 255) exp_err++;
               break;
            end
         end
      end
      chk("data",     32'(data),  32'(exp_data));
      chk("l_vld",    32'(l_vld), 32'(el));
      chk("r_vld",    32'(r_vld), 32'(er));
      chk("synced",   32'(synced), 32'(exp_syn));
      chk("vld_excl", 32'(l_vld & r_vld), 32'd0);
`ifdef I2S_RX_ERR_EN
      chk("err_cnt",  32'(err_cnt), 32'(exp_err));
`endif
      if (l_vld) begin last_l = data; l_cnt++; end
      if (r_vld) begin last_r = data; r_cnt++; end
      if (b2b_on && (l_vld || r_vld)) begin
         if (last_vld_n >= 0) chk("b2b_gap", 32'(n - last_vld_n), 32'd8);
         last_vld_n = n;
         b2b_cnt++;
      end
   endtask

   task automatic tick(input logic lr_v, input logic sd_v);
      lrck  = lr_v;
      sdata = sd_v;
      en    = en_drv;
      @(posedge sck);
      if (n >= HMAX) begin
         $display("FAIL history_overflow: got %0d expected below %0d", n, HMAX);
         $fatal(1, "history overflow");
      end
      lr_h[n] = lr_v;
      sd_h[n] = sd_v;
      en_h[n] = en_drv;
      #1;
      model_eval();
      n++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_data",   32'(data),   32'd0);
      chk("rst_l_vld",  32'(l_vld),  32'd0);
      chk("rst_r_vld",  32'(r_vld),  32'd0);
      chk("rst_synced", 32'(synced), 32'd0);
`ifdef I2S_RX_ERR_EN
      chk("rst_err",    32'(err_cnt), 32'd0);
`endif
      @(posedge sck);
      @(posedge sck);
      #2;
      rst_n    = 1'b1;
      n        = 0;
      exp_syn  = 1'b0;
      exp_data = 8'h00;
      exp_err  = 0;
   endtask

   // One channel slot of len sck cycles: cycle 0 carries the previous slot's
   // LSB, then the word MSB-first, then filler bits.
   task automatic slot(input logic ch, input int len, input logic [7:0] w,
                       input int drop_at, input int rst_at);
      for (int k = 0; k < len; k++) begin
         logic b;
         int   idx;
         if (k == 0) b = pend;
         else begin
            idx = DW - k;
            b = (idx >= 0) ? w[idx] : 1'($urandom_range(0, 1));
         end
         en_drv = !(drop_at >= 0 && k >= drop_at && k < drop_at + 2);
         tick(ch, b);
         if (k == rst_at) do_reset();
      end
      en_drv = 1'b1;
      pend = (len <= DW) ? w[DW-len] : 1'($urandom_range(0, 1));
   endtask

   initial begin
      int lc0;
      int err0;
      logic ch;
      #1;
      do_reset();

      // stereo 32-sck frames
      for (int f = 0; f < 3; f++) begin
         slot(1'b0, 16, 8'hA5, -1, -1);
         slot(1'b1, 16, 8'h3C, -1, -1);
      end
      chk("stereo_L",    32'(last_l), 32'hA5);
      chk("stereo_R",    32'(last_r), 32'h3C);
      chk("stereo_Lcnt", 32'(l_cnt),  32'd2);

      // back-to-back 8-bit slots
      b2b_on = 1'b1; b2b_cnt = 0; last_vld_n = -1;
      for (int f = 0; f < 4; f++) begin
         slot(1'b0, 8, 8'h81, -1, -1);
         slot(1'b1, 8, 8'h7E, -1, -1);
      end
      slot(1'b0, 8, 8'h81, -1, -1);
      b2b_on = 1'b0;
      chk("b2b_cnt", 32'(b2b_cnt), 32'd8);
      chk("b2b_L",   32'(last_l),  32'h81);
      chk("b2b_R",   32'(last_r),  32'h7E);

      // short slot followed by a full one
`ifdef I2S_RX_ERR_EN
      err0 = int'(err_cnt);
`else
      err0 = 0;
`endif
      slot(1'b1, 5,  8'h00, -1, -1);
      slot(1'b0, 8,  8'hFF, -1, -1);
      slot(1'b1, 16, 8'h42, -1, -1);
      chk("short_word", 32'(last_l), 32'hFF);
`ifdef I2S_RX_ERR_EN
      chk("err_inc", 32'(int'(err_cnt) - err0), 32'd1);
`endif

      // enable dropped at bit 4
      lc0 = l_cnt;
      slot(1'b0, 16, 8'h5A, 4, -1);
      slot(1'b1, 16, 8'hC3, -1, -1);
      slot(1'b0, 16, 8'h24, -1, -1);
      chk("endrop_lcnt", 32'(l_cnt - lc0), 32'd1);
      chk("endrop_L",    32'(last_l), 32'h24);
      chk("endrop_R",    32'(last_r), 32'hC3);

      // reset pulsed mid-slot, then recovery
      slot(1'b1, 16, 8'h96, -1, 5);
      slot(1'b0, 16, 8'h5A, -1, -1);
      slot(1'b1, 16, 8'hC3, -1, -1);
      slot(1'b0, 16, 8'h11, -1, -1);
      chk("rst_recover_L", 32'(last_l), 32'h11);
      chk("rst_recover_R", 32'(last_r), 32'hC3);

      // randomized slots
      ch = 1'b1;
      for (int s = 0; s < 150; s++) begin
         int len;
         int drop;
         len  = $urandom_range(2, 20);
         drop = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
         slot(ch, len, 8'($urandom), drop, -1);
         ch = ~ch;
      end

      // long run of short slots
      for (int s = 0; s < 300; s++) begin
         slot(ch, 2, 8'($urandom), -1, -1);
         ch = ~ch;
      end
`ifdef I2S_RX_ERR_EN
      chk("err_sat", 32'(err_cnt), 32'hFF);
`endif
      slot(ch, 16, 8'h6D, -1, -1);
      slot(~ch, 16, 8'hB2, -1, -1);
      chk("final_word", 32'(ch == WSL ? last_l : last_r), 32'h6D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
